// File: rtl/muldiv_seq_32.sv
// ---------------------------------------------------------------------------
// muldiv_seq_32 : sequential 32-bit multiply / divide unit.
//
// One shift-add (multiply) or restoring-subtract (divide) iteration per
// clock, 32 iterations per operation, 64-bit HI:LO result.
//
// Optional feature macro: SIGNED_MD_EN
//   defined   : op[1]=1 selects signed MULT/DIV (magnitudes + FIX state).
//   undefined : op[1] is ignored, MULT/DIV behave as MULTU/DIVU.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   operation request, sampled only while idle
//   op[1:0]   in   00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   A[31:0]   in   multiplicand / dividend
//   B[31:0]   in   multiplier / divisor
//   busy      out  operation in progress
//   done      out  one-cycle pulse, results just updated
//   hi[31:0]  out  product[63:32] or remainder
//   lo[31:0]  out  product[31:0] or quotient
//   zero      out  registered (lo == 0)
//   div_zero  out  last completed divide had B == 0
// ---------------------------------------------------------------------------
module muldiv_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        zero,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  // Multiply: full 64-bit accumulator {upper, multiplier}.
  // Divide:   acc_r[31:0] holds the quotient shifting in from the dividend.
  logic [63:0] acc_r;
  logic [31:0] rem_r;     // divide remainder (always < divisor after a step)
  logic [31:0] mcand_r;   // multiplicand magnitude or divisor magnitude
  logic        is_div_r;
  logic        dz_r;      // operation is a divide by zero

`ifdef SIGNED_MD_EN
  logic        signed_r;
  logic        neg_q_r;   // negate product / quotient
  logic        neg_r_r;   // negate remainder
  logic        sgn_op_s;
`endif

  logic        is_div_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_sh_s;
  logic        div_ge_s;
  logic [31:0] rem_nx_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // Operation decode and operand magnitude conversion
  always_comb begin
    is_div_s = 1'b0;
    // Full-width decode keeps op[1] consumed even when it is functionally ignored.
    case (op)
      2'b00:   is_div_s = 1'b0;
      2'b01:   is_div_s = 1'b1;
      2'b10:   is_div_s = 1'b0;
      2'b11:   is_div_s = 1'b1;
      default: is_div_s = 1'b0;
    endcase
`ifdef SIGNED_MD_EN
    sgn_op_s = op[1];
    if (sgn_op_s && A[31]) begin
      a_mag_s = 32'd0 - A;
    end else begin
      a_mag_s = A;
    end
    if (sgn_op_s && B[31]) begin
      b_mag_s = 32'd0 - B;
    end else begin
      b_mag_s = B;
    end
`else
    a_mag_s = A;
    b_mag_s = B;
`endif
  end

  // One multiply and one divide iteration, plus result selection for OUT
  always_comb begin
    mul_sum_s = {1'b0, acc_r[63:32]} + {1'b0, mcand_r};
    if (acc_r[0]) begin
      mul_next_s = {mul_sum_s, acc_r[31:1]};
    end else begin
      mul_next_s = {1'b0, acc_r[63:1]};
    end
    div_sh_s = {rem_r, acc_r[31]};
    div_ge_s = (div_sh_s >= {1'b0, mcand_r});
    // When the subtract happens the true difference is below 2^32,
    // so a 32-bit modular subtract is exact.
    if (div_ge_s) begin
      rem_nx_s = div_sh_s[31:0] - mcand_r;
    end else begin
      rem_nx_s = div_sh_s[31:0];
    end
    if (is_div_r) begin
      res_hi_s = rem_r;
      res_lo_s = acc_r[31:0];
    end else begin
      res_hi_s = acc_r[63:32];
      res_lo_s = acc_r[31:0];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      acc_r    <= 64'd0;
      rem_r    <= 32'd0;
      mcand_r  <= 32'd0;
      is_div_r <= 1'b0;
      dz_r     <= 1'b0;
`ifdef SIGNED_MD_EN
      signed_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      zero     <= 1'b1;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            is_div_r <= is_div_s;
            cnt_r    <= 5'd0;
`ifdef SIGNED_MD_EN
            signed_r <= sgn_op_s;
            neg_q_r  <= sgn_op_s & (A[31] ^ B[31]);
            neg_r_r  <= sgn_op_s & A[31];
`endif
            if (is_div_s && (B == 32'd0)) begin
              // Divide by zero: load the fixed result and skip CALC; busy stays low.
              dz_r    <= 1'b1;
              rem_r   <= A;
              acc_r   <= {32'd0, 32'hFFFF_FFFF};
              state_r <= ST_OUT;
            end else begin
              dz_r    <= 1'b0;
              busy    <= 1'b1;
              rem_r   <= 32'd0;
              state_r <= ST_CALC;
              if (is_div_s) begin
                acc_r   <= {32'd0, a_mag_s};
                mcand_r <= b_mag_s;
              end else begin
                acc_r   <= {32'd0, b_mag_s};
                mcand_r <= a_mag_s;
              end
            end
          end
        end
        ST_CALC: begin
          if (is_div_r) begin
            acc_r <= {acc_r[63:32], acc_r[30:0], div_ge_s};
            rem_r <= rem_nx_s;
          end else begin
            acc_r <= mul_next_s;
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
`ifdef SIGNED_MD_EN
            state_r <= signed_r ? ST_FIX : ST_OUT;
`else
            state_r <= ST_OUT;
`endif
          end
        end
`ifdef SIGNED_MD_EN
        ST_FIX: begin
          if (is_div_r) begin
            if (neg_q_r) begin
              acc_r <= {acc_r[63:32], 32'd0 - acc_r[31:0]};
            end
            if (neg_r_r) begin
              rem_r <= 32'd0 - rem_r;
            end
          end else if (neg_q_r) begin
            acc_r <= 64'd0 - acc_r;
          end
          state_r <= ST_OUT;
        end
`endif
        ST_OUT: begin
          hi       <= res_hi_s;
          lo       <= res_lo_s;
          zero     <= (res_lo_s == 32'd0);
          div_zero <= dz_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq_32.md
# muldiv_seq_32

Sequential 32-bit multiply/divide unit for the CPU datapath. It runs one shift-add or restoring-subtract iteration per clock and writes a 64-bit HI:LO result. It also produces a registered zero flag on LO, which feeds the same branch/flag logic as the ALU zero detector. Operands come from the register-file read stage; results are consumed by MFHI/MFLO writeback.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV (signed ops only with SIGNED_MD_EN)
- A  in  32  multiplicand / dividend
- B  in  32  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: hi/lo/zero/div_zero just updated
- hi  out  32  product[63:32] or remainder
- lo  out  32  product[31:0] or quotient
- zero  out  1  registered (lo == 0)
- div_zero  out  1  last divide had B == 0

## Operation
- States:
  - IDLE: start=1 latches A, B and op, clears the iteration counter, goes to CALC.
  - CALC: 32 iterations, counter 0..31. After 31 goes to FIX if signed, else OUT.
  - FIX: signed sign correction only.
  - OUT: writes hi/lo/zero, pulses done, returns to IDLE.
- MULTU: 64-bit accumulator. Each iteration adds the multiplicand to the upper half when the LSB is 1, then shifts right 1.
- DIVU: restoring divide with remainder register R (33 bits) and quotient Q.
  - Each iteration shifts {R,Q} left 1.
  - If R ≥ divisor: subtract and set Q[0] = 1.
  - Result: lo = Q, hi = R[31:0].
- Divide by zero (op DIVU/DIV, B == 0):
  - IDLE goes directly to OUT with no iterations.
  - hi = A, lo = 32'hFFFF_FFFF, div_zero = 1.
- div_zero is cleared by any other completed operation.
- start while busy=1 is ignored; operands are not re-latched.
- hi/lo/zero/div_zero hold their values between operations.
- Reset values:
  - hi = 0, lo = 0, zero = 1, busy = 0, done = 0, div_zero = 0.
  - State = IDLE.
- rst mid-operation aborts the operation. All outputs take their reset values on the next edge and no done pulse is issued.

## Timing
- start sampled high at edge E0. busy = 1 from E0 through the last CALC/FIX cycle.
- Unsigned ops: done = 1 and busy = 0 after edge E33; results are valid in the same cycle.
- Signed ops: add 1 cycle for FIX, so done after E34.
- Divide by zero: done after E1; busy is never asserted.
- A start sampled in the done cycle is accepted; back-to-back throughput is 34 cycles for unsigned ops.
- zero and hi/lo change only on the done edge.

## Configuration
- SIGNED_MD_EN defined:
  - op[1]=1 converts A and B to magnitudes, runs the unsigned core, then FIX applies signs.
  - MULT: negates the 64-bit product if sign(A) ^ sign(B).
  - DIV: the quotient takes sign(A) ^ sign(B); the remainder takes sign(A).
  - 0x8000_0000 / -1 gives lo = 0x8000_0000, hi = 0.
- SIGNED_MD_EN undefined:
  - op[1] is ignored; MULT/DIV execute as MULTU/DIVU at unsigned latency.
  - No FIX state or negation logic is synthesized.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF, start at E0 → done after E33: hi = 0xFFFF_FFFE, lo = 0x0000_0001, zero = 0.
- MULTU 0x0001_0000 × 0x0001_0000 → hi = 1, lo = 0, zero = 1. Then DIVU 100 / 7 → lo = 14, hi = 2, zero = 0, div_zero = 0.
- DIVU 5 / 0 → done after E1, busy never high: hi = 5, lo = 0xFFFF_FFFF, div_zero = 1. A following DIVU 8 / 2 → div_zero = 0, lo = 4.
- Start DIVU 9 / 3, pulse start with A = 1, B = 1 at E5, then assert rst at E10:
  - The E5 start is ignored.
  - After E10: busy = 0, hi = lo = 0, zero = 1.
  - No done pulse is issued.
- With SIGNED_MD_EN:
  - MULT −3 × 5 → done after E34: hi = 0xFFFF_FFFF, lo = 0xFFFF_FFF1.
  - DIV −7 / 2 → lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF.
- Without SIGNED_MD_EN: op = 10, 0xFFFF_FFFF × 2 → done after E33: hi = 1, lo = 0xFFFF_FFFE.
